// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle controller: state encoding, opcodes, ALU codes.
// ADDIEX/ADDIWB exist only when MULTICYCLE_CTRL_ADDI_EN is defined.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
`ifdef MULTICYCLE_CTRL_ADDI_EN
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`endif
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU control decode: maps aluop (and funct for R-type) onto the ALU F encoding.
// Purely combinational; unknown aluop/funct fall back to add so the output is never X.
module mc_aludec
  import multicycle_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath with a shared, variable-latency memory.
// Optional ADDI support is compiled in with MULTICYCLE_CTRL_ADDI_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               memready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcen,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic       illegal_q;
  logic       illegal_d;

  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       irwrite_raw;
  logic       memwrite_raw;
  logic       regwrite_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = FETCH;
    illegal_d    = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;

    case (state_q)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = memready;
        pcwrite     = memready;
        state_d     = memready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is dispatched.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = FETCH;
      end
`endif
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write enables are qualified by reset so a pending memready cannot leak through while held.
  assign irwrite  = irwrite_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign illegal  = illegal_q;
  assign state    = STATE_W'(state_q);

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: per-instruction expected cycle traces are queued,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memready = 1'b0;
  logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctl;
    logic       illegal;
  } obs_t;

  obs_t       expq[$];
  string      nameq[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_funct = 6'd0;
  bit         pend_ill = 1'b0;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.aluctl = 3'b010;
    return e;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic chk(input bit ok, input string nm);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s t=%0t: st=%0d iord=%b mw=%b irw=%b pcen=%b rw=%b ill=%b",
               nm, $time, state, iord, memwrite, irwrite, pcen, regwrite, illegal);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      obs_t  e;
      obs_t  act;
      string nm;
      e  = expq.pop_front();
      nm = nameq.pop_front();
      act = {state, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, alucontrol, illegal};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s t=%0t: got st=%0d iord/mw/irw/pcen/rw/rd/m2r/asa=%b%b%b%b%b%b%b%b asb=%b pcs=%b alu=%b ill=%b; want st=%0d %b%b%b%b%b%b%b%b asb=%b pcs=%b alu=%b ill=%b",
                 nm, $time, act.st, act.iord, act.memwrite, act.irwrite, act.pcen, act.regwrite,
                 act.regdst, act.memtoreg, act.alusrca, act.alusrcb, act.pcsrc, act.aluctl, act.illegal,
                 e.st, e.iord, e.memwrite, e.irwrite, e.pcen, e.regwrite, e.regdst, e.memtoreg,
                 e.alusrca, e.alusrcb, e.pcsrc, e.aluctl, e.illegal);
      end
    end
  end

  task automatic cyc(input logic mr, input logic z, input obs_t e, input string nm);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    op       = cur_op;
    funct    = cur_funct;
    memready = mr;
    zero     = z;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  task automatic rst_cyc(input logic mr, input string nm);
    obs_t e;
    e = blank(FETCH);
    e.alusrcb = 2'b01;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    memready = mr;
    zero     = rb();
    pend_ill = 1'b0;
    expq.push_back(e);
    nameq.push_back(nm);
    #1;
    chk((state === 4'(FETCH)) && (illegal === 1'b0) && (irwrite === 1'b0) && (pcen === 1'b0) &&
        (regwrite === 1'b0) && (memwrite === 1'b0), "reset_state_immediate");
  endtask

  // One instruction: fw/mw = memready-low cycles in fetch/memory, zf<0 random zero in BRANCH,
  // rst_at>=0 asserts reset after that many memory-wait cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                           input int zf, input int rst_at);
    obs_t e;
    logic mr;
    logic z;
    cur_op    = o;
    cur_funct = f;
    for (int i = 0; i <= fw; i++) begin
      mr = (i == fw);
      e = blank(FETCH);
      e.alusrcb = 2'b01;
      e.irwrite = mr;
      e.pcen    = mr;
      e.illegal = (i == 0) && pend_ill;
      cyc(mr, rb(), e, "fetch");
    end
    pend_ill = 1'b0;
    e = blank(DECODE);
    e.alusrcb = 2'b11;
    cyc(rb(), rb(), e, "decode");
    if (o == OP_LW || o == OP_SW) begin
      e = blank(MEMADR);
      e.alusrca = 1'b1;
      e.alusrcb = 2'b10;
      cyc(rb(), rb(), e, "memadr");
      for (int i = 0; i <= mw; i++) begin
        if (i == rst_at) begin
          rst_cyc(1'b1, "reset_mid_access");
          rst_cyc(1'b1, "reset_mid_access");
          return;
        end
        mr = (i == mw);
        e = blank((o == OP_LW) ? MEMRD : MEMWR);
        e.iord     = 1'b1;
        e.memwrite = (o == OP_SW);
        cyc(mr, rb(), e, (o == OP_LW) ? "memrd" : "memwr");
      end
      chk((state === ((o == OP_LW) ? 4'(MEMRD) : 4'(MEMWR))) && (iord === 1'b1),
          "mem_wait_expired");
      if (o == OP_LW) begin
        e = blank(MEMWB);
        e.regwrite = 1'b1;
        e.memtoreg = 1'b1;
        cyc(rb(), rb(), e, "memwb");
      end
    end else if (o == OP_RTYPE) begin
      e = blank(EXECUTE);
      e.alusrca = 1'b1;
      e.aluctl  = alu_ref(f);
      cyc(rb(), rb(), e, "execute");
      e = blank(ALUWB);
      e.regwrite = 1'b1;
      e.regdst   = 1'b1;
      cyc(rb(), rb(), e, "aluwb");
    end else if (o == OP_BEQ) begin
      z = (zf < 0) ? rb() : logic'(zf[0]);
      e = blank(BRANCH);
      e.alusrca = 1'b1;
      e.aluctl  = 3'b110;
      e.pcsrc   = 2'b01;
      e.pcen    = z;
      cyc(rb(), z, e, "branch");
    end else if (o == OP_J) begin
      e = blank(JUMP);
      e.pcsrc = 2'b10;
      e.pcen  = 1'b1;
      cyc(rb(), rb(), e, "jump");
`ifdef MULTICYCLE_CTRL_ADDI_EN
    end else if (o == OP_ADDI) begin
      e = blank(ADDIEX);
      e.alusrca = 1'b1;
      e.alusrcb = 2'b10;
      cyc(rb(), rb(), e, "addiex");
      e = blank(ADDIWB);
      e.regwrite = 1'b1;
      cyc(rb(), rb(), e, "addiwb");
`endif
    end else begin
      pend_ill = 1'b1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return OP_RTYPE;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      6: return 6'b111111;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    rst_cyc(1'b0, "reset");
    rst_cyc(1'b1, "reset_memready_high");
    run_instr(OP_RTYPE, 6'b100000, 0, 0, -1, -1);
    run_instr(OP_LW, 6'b000000, 0, 3, -1, -1);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1, -1);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 0, -1);
    run_instr(6'b111111, 6'b000000, 0, 0, -1, -1);
    run_instr(OP_SW, 6'b000000, 1, 2, -1, -1);
    run_instr(OP_ADDI, 6'b000000, 0, 0, -1, -1);
    run_instr(OP_J, 6'b000000, 0, 0, -1, -1);
    run_instr(OP_RTYPE, 6'b101010, 0, 0, -1, -1);
    run_instr(OP_LW, 6'b000000, 0, 5, -1, 2);
    run_instr(OP_RTYPE, 6'b100010, 2, 0, -1, -1);
    for (int n = 0; n < 400; n++) begin
      logic [5:0] o;
      int         mw;
      int         ra;
      o  = pick_op();
      mw = $urandom_range(0, 3);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, mw) : -1;
      run_instr(o, pick_funct(), $urandom_range(0, 2), mw, -1, ra);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter STATE_W, default 4, the width of the state encoding.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port op, input, 6 bits: instr[31:26] from the instruction register.
REQ-005 SHALL have port funct, input, 6 bits: instr[5:0].
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port memready, input, 1 bit: the shared memory access completes this cycle.
REQ-008 SHALL have these 1-bit output ports: iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca.
REQ-009 SHALL have output ports alusrcb (2 bits), pcsrc (2 bits) and alucontrol (3 bits), with the same encoding as the existing ALU F input.
REQ-010 SHALL have output ports illegal (1 bit) and state (STATE_W bits), the debug view of the current state.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; outputs decode from state only, except pcen.
REQ-012 SHALL, in FETCH, drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite and pcwrite assert only when memready=1, else FSM holds in FETCH.
REQ-013 SHALL go FETCH->DECODE on memready; DECODE drives alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
REQ-014 SHALL dispatch from DECODE: LW/SW->MEMADR, R-type->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP; any other op->FETCH with illegal=1 for exactly one cycle.
REQ-015 SHALL in MEMADR drive alusrca=1, alusrcb=10, aluop=00; then go to MEMRD (LW) or MEMWR (SW).
REQ-016 SHALL in MEMRD drive iord=1 and hold until memready, then go to MEMWB; MEMWB drives regwrite=1, regdst=0, memtoreg=1, then FETCH.
REQ-017 SHALL in MEMWR drive iord=1 and memwrite=1, hold until memready, then go to FETCH.
REQ-018 SHALL in EXECUTE drive alusrca=1, alusrcb=00, aluop=10, then go to ALUWB; ALUWB drives regwrite=1, regdst=1, memtoreg=0, then FETCH.
REQ-019 SHALL in BRANCH drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then FETCH.
REQ-020 SHALL in JUMP drive pcsrc=10, pcwrite=1, then FETCH.
REQ-021 SHALL compute pcen = pcwrite | (branch & zero) combinationally.
REQ-022 SHALL decode alucontrol from aluop: 00->010, 01->110, 10->funct (100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111, other 010).
REQ-023 SHALL drive every unlisted output to 0 in every state; alucontrol SHALL never be X.

Reset
REQ-024 SHALL, while reset=1, force state=FETCH, illegal=0 and all write enables (irwrite, pcen, regwrite, memwrite) to 0, regardless of memready.
REQ-025 SHALL abandon any in-flight access when reset asserts mid-instruction; the first post-reset fetch starts on the first clk edge after deassertion.

Configuration
REQ-026 SHALL, with MULTICYCLE_CTRL_ADDI_EN defined, decode op 001000 via ADDIEX (alusrca=1, alusrcb=10, aluop=00) then ADDIWB (regwrite=1, regdst=0, memtoreg=0).
REQ-027 SHALL, without MULTICYCLE_CTRL_ADDI_EN, treat op 001000 as illegal per REQ-014, and ADDIEX/ADDIWB SHALL not exist.

Structure
REQ-028 SHALL take the state enum, opcode constants (RTYPE, LW, SW, BEQ, ADDI, J) and aluop encodings from the shared package multicycle_pkg.
REQ-029 SHALL place the aluop/funct->alucontrol decode in one sub-module, mc_aludec; the FSM and output decode stay in multicycle_ctrl.

Verification
REQ-030 SHALL check reset: assert reset in MEMRD -> state=FETCH, all enables 0 immediately; after release, irwrite=1 once memready=1.
REQ-031 SHALL check R-type add: op=000000, funct=100000, memready=1 -> FETCH, DECODE, EXECUTE(alucontrol=010), ALUWB(regwrite=1, regdst=1), FETCH; 4 cycles.
REQ-032 SHALL check LW with memready low for 3 cycles in MEMRD -> state holds in MEMRD, iord=1; MEMWB follows, total 8 cycles.
REQ-033 SHALL check BEQ: zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0; alucontrol=110 in both cases.
REQ-034 SHALL check illegal op 111111 -> illegal=1 for one cycle after DECODE, next state FETCH, no write enable asserted.
REQ-035 SHALL check ADDI under both macro settings: defined -> ADDIWB with regwrite=1; undefined -> illegal pulse.
